// File: rtl/cpu_seq_controller.sv
// Multi-cycle sequencing controller for the 32-bit RISC datapath: fetch, decode and a
// fixed per-class state walk, with the PC and every datapath strobe held in flops.
module cpu_seq_controller #(
    parameter int unsigned         PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    output logic                instr_re_o,
    input  logic [31:0]         instr_rdata_i,
    output logic [PC_WIDTH-1:0] pc_o,
    input  logic [31:0]         a_val_i,
    input  logic [31:0]         b_val_i,
    output logic                rb_rd1_en_o,
    output logic                rb_rd2_en_o,
    output logic                rb_wr_en_o,
    output logic [4:0]          rs1_o,
    output logic [4:0]          rs2_o,
    output logic [4:0]          rd_o,
    output logic [31:0]         imm_o,
    output logic                sel_a_o,
    output logic                sel_r_o,
    output logic [3:0]          alu_op_o,
    output logic                dm_we_o,
    output logic                dm_re_o,
    output logic                halted_o
);

    typedef enum logic [2:0] {S_IF, S_ID, S_RR, S_EX, S_MEM, S_WB, S_HALT} state_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       sel_a;
        logic       sel_r;
        logic [3:0] alu_op;
        logic       rd1_en;
        logic       rd2_en;
    } decode_t;

    state_e              state_q;
    logic [31:5]         ir_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic                instr_re_q, rd1_en_q, rd2_en_q, wr_en_q, dm_we_q, dm_re_q, halted_q;
    logic [4:0]          rs1_q, rs2_q, rd_q;
    logic [31:0]         imm_q;
    logic                sel_a_q, sel_r_q;
    logic [3:0]          alu_op_q;

    decode_t             dec_d;
    logic [2:0]          id_op, id_fn;
    logic                branch_taken;
    logic [PC_WIDTH-1:0] pc_inc;

    function automatic logic [3:0] alu_map(input logic [2:0] fn);
        case (fn)
            3'd0:    return 4'b0000;
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0010;
            3'd3:    return 4'b0011;
            3'd4:    return 4'b0100;
            3'd5:    return 4'b0110;
            3'd6:    return 4'b0111;
            default: return 4'b1000;
        endcase
    endfunction

    assign id_op  = instr_rdata_i[31:29];
    assign id_fn  = instr_rdata_i[28:26];
    assign pc_inc = pc_q + PC_WIDTH'(1);

    // Decoded straight from the fetch bus so the fields are valid from RR onward.
    always_comb begin
        dec_d        = '0;
        dec_d.alu_op = 4'b1001;
        case (id_op)
            3'b001: begin
                dec_d.rs1    = instr_rdata_i[9:5];
                dec_d.rs2    = instr_rdata_i[14:10];
                dec_d.rd     = instr_rdata_i[4:0];
                dec_d.sel_a  = 1'b1;
                dec_d.sel_r  = 1'b1;
                dec_d.alu_op = alu_map(id_fn);
                dec_d.rd1_en = 1'b1;
                dec_d.rd2_en = 1'b1;
            end
            3'b010: begin
                dec_d.rs2    = instr_rdata_i[9:5];
                dec_d.rd     = instr_rdata_i[4:0];
                dec_d.sel_r  = 1'b1;
                dec_d.alu_op = alu_map(id_fn);
                dec_d.rd2_en = 1'b1;
            end
            3'b011: begin
                dec_d.rd     = instr_rdata_i[4:0];
                dec_d.sel_r  = 1'b1;
                dec_d.alu_op = 4'b0101;
                if (!id_fn[0]) begin
                    dec_d.rs1    = instr_rdata_i[9:5];
                    dec_d.sel_a  = 1'b1;
                    dec_d.rd1_en = 1'b1;
                end
            end
            3'b100: begin
                dec_d.rs2    = instr_rdata_i[9:5];
                dec_d.alu_op = 4'b0000;
                dec_d.rd2_en = 1'b1;
                case (id_fn[2:1])
                    2'b00: dec_d.rd = instr_rdata_i[4:0];
                    2'b01: dec_d.rd = 5'd31;
                    2'b10: begin
                        dec_d.rs1    = 5'd31;
                        dec_d.rd1_en = 1'b1;
                    end
                    default: begin
                        dec_d.rs1    = instr_rdata_i[4:0];
                        dec_d.rd1_en = 1'b1;
                    end
                endcase
            end
            3'b101: begin
                dec_d.rs2    = instr_rdata_i[4:0];
                dec_d.rd2_en = 1'b1;
            end
            3'b110: begin
                dec_d.rs1    = 5'd31;
                dec_d.rd     = 5'd31;
                dec_d.sel_a  = 1'b1;
                dec_d.sel_r  = 1'b1;
                dec_d.rd1_en = 1'b1;
                case (id_fn[2:1])
                    2'b01:   dec_d.alu_op = 4'b1011;
                    2'b00:   dec_d.alu_op = 4'b1001;
                    default: dec_d.alu_op = 4'b1010;
                endcase
            end
            3'b111: begin
                dec_d.rs1    = instr_rdata_i[9:5];
                dec_d.rd     = instr_rdata_i[4:0];
                dec_d.sel_a  = 1'b1;
                dec_d.sel_r  = 1'b1;
                dec_d.rd1_en = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ir_q[28:27])
            2'b00:   branch_taken = (b_val_i == 32'd0);
            2'b01:   branch_taken = b_val_i[31];
            2'b10:   branch_taken = !b_val_i[31] && (b_val_i != 32'd0);
            default: branch_taken = 1'b1;
        endcase
    end

    // Strobes default low each cycle and are raised on the transition into their state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IF;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            instr_re_q <= 1'b0;
            rd1_en_q   <= 1'b0;
            rd2_en_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_re_q    <= 1'b0;
            halted_q   <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            sel_a_q    <= 1'b0;
            sel_r_q    <= 1'b0;
            alu_op_q   <= 4'b1001;
        end else begin
            instr_re_q <= 1'b0;
            rd1_en_q   <= 1'b0;
            rd2_en_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_re_q    <= 1'b0;
            case (state_q)
                S_IF: begin
                    // The IF cycle straight out of reset has no fetch yet; issue it first.
                    if (instr_re_q) state_q <= S_ID;
                    else            instr_re_q <= 1'b1;
                end
                S_ID: begin
                    ir_q     <= instr_rdata_i[31:5];
                    rs1_q    <= dec_d.rs1;
                    rs2_q    <= dec_d.rs2;
                    rd_q     <= dec_d.rd;
                    sel_a_q  <= dec_d.sel_a;
                    sel_r_q  <= dec_d.sel_r;
                    alu_op_q <= dec_d.alu_op;
                    imm_q    <= {{17{instr_rdata_i[25]}}, instr_rdata_i[24:10]};
                    if (id_op != 3'b000) begin
                        state_q  <= S_RR;
                        rd1_en_q <= dec_d.rd1_en;
                        rd2_en_q <= dec_d.rd2_en;
                    end else if (id_fn[2]) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        pc_q       <= pc_inc;
                        state_q    <= S_IF;
                        instr_re_q <= 1'b1;
                    end
                end
                S_RR: state_q <= S_EX;
                S_EX: begin
                    if (ir_q[31:29] == 3'b101) begin
                        pc_q       <= branch_taken ? PC_WIDTH'({10'b0, ir_q[26:5]}) : pc_inc;
                        state_q    <= S_IF;
                        instr_re_q <= 1'b1;
                    end else if (ir_q[31:29] == 3'b100) begin
                        state_q <= S_MEM;
                        dm_we_q <= ir_q[28];
                        dm_re_q <= !ir_q[28];
                    end else if (ir_q[31:29] == 3'b110 && ir_q[28:27] == 2'b00) begin
                        pc_q       <= PC_WIDTH'(a_val_i);
                        state_q    <= S_IF;
                        instr_re_q <= 1'b1;
                    end else begin
                        state_q <= S_WB;
                        wr_en_q <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (ir_q[28]) begin
                        pc_q       <= pc_inc;
                        state_q    <= S_IF;
                        instr_re_q <= 1'b1;
                    end else begin
                        state_q <= S_WB;
                        wr_en_q <= 1'b1;
                    end
                end
                S_WB: begin
                    if (ir_q[31:29] == 3'b110 && ir_q[28:27] == 2'b11)
                        pc_q <= pc_q + PC_WIDTH'(imm_q);
                    else
                        pc_q <= pc_inc;
                    state_q    <= S_IF;
                    instr_re_q <= 1'b1;
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_IF;
            endcase
        end
    end

    assign instr_re_o  = instr_re_q;
    assign pc_o        = pc_q;
    assign rb_rd1_en_o = rd1_en_q;
    assign rb_rd2_en_o = rd2_en_q;
    assign rb_wr_en_o  = wr_en_q;
    assign rs1_o       = rs1_q;
    assign rs2_o       = rs2_q;
    assign rd_o        = rd_q;
    assign imm_o       = imm_q;
    assign sel_a_o     = sel_a_q;
    assign sel_r_o     = sel_r_q;
    assign alu_op_o    = alu_op_q;
    assign dm_we_o     = dm_we_q;
    assign dm_re_o     = dm_re_q;
    assign halted_o    = halted_q;

endmodule

// File: doc/cpu_seq_controller.md
Name: cpu_seq_controller

Overview:
- Multi-cycle control FSM for the 32-bit RISC datapath: register bank (2 read ports, 1 write port), ALU, 1K-word data BRAM and stack pointer R31.
- Fetches from the instruction memory, decodes opcode[31:29] and func[28:26], and sequences each instruction through fixed states.
- Drives every datapath control strobe and owns the PC.
- Replaces the single-cycle always block, so register reads, BRAM reads and write-back never overlap within one instruction.

Parameters:
- PC_WIDTH, 32, width of pc output.
- RESET_PC, 0, pc value after reset.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_re  out  1  instruction-memory read strobe; data is valid on instr_rdata one cycle later
- instr_rdata  in  32  fetched instruction
- pc  out  PC_WIDTH  current program counter (instruction-memory address)
- a_val  in  32  register-bank read port 1 data (for RETURN)
- b_val  in  32  register-bank read port 2 data (signed, for branch tests)
- rb_rd1_en, rb_rd2_en, rb_wr_en  out  1 each  register-bank port enables
- rs1, rs2, rd  out  5 each  register addresses
- imm  out  32  sign-extended immediate
- sel_a  out  1  1 = ALU A input from port 1; 0 = from imm
- sel_r  out  1  1 = write-back from ALU; 0 = from BRAM
- alu_op  out  4  ALU opcode (0000 add … 1100 passB)
- dm_we, dm_re  out  1 each  BRAM write/read strobes
- halted  out  1  high once HALT has retired

Behaviour:
- Reset (async, rst_n=0):
  - state=IF, pc=RESET_PC, IR=0.
  - All strobes 0, rs1/rs2/rd=0, imm=0, sel_a=0, sel_r=0, alu_op=1001, halted=0.
  - Reset asserted mid-instruction aborts it; no write strobe may remain high.
- States are IF, ID, RR, EX, MEM, WB, HALT. Every strobe is registered and high for exactly one cycle in its state; all strobes are 0 elsewhere.
- IF: instr_re=1. Next state ID.
- ID:
  - Latch IR=instr_rdata.
  - Drive rs1/rs2/rd/imm; imm = {17{IR[25]}, IR[24:10]}.
  - opcode 000: func[2]=0 is NOP (pc+=1, next IF); func[2]=1 goes to HALT.
  - Otherwise next state RR.
- RR: assert the read enables for the class (port data is registered). Next state EX.
- EX: hold alu_op/sel_a valid.
  - Branches retire here.
  - LOAD/STORE go to MEM.
  - RETURN retires here.
  - All other classes go to WB.
- Class decode:
  - 001 ALU: rs1=IR[9:5], rs2=IR[14:10], rd=IR[4:0], sel_a=1, sel_r=1. func 0..7 maps to alu_op 0000,0001,0010,0011,0100,0110,0111,1000.
  - 010 ALUI: rs2=IR[9:5], sel_a=0, same func map.
  - 011 NOT/NOTI: alu_op=0101; func 0 uses rs1=IR[9:5] with sel_a=1; func 1 uses sel_a=0.
  - 100 LD/ST: rs2=IR[9:5].
    - func[2:1]=0 LOAD (rd=IR[4:0]); =1 LOAD-SP (rd=31).
    - =3 STORE (rs1=IR[4:0]); =2 STORE-SP (rs1=31).
    - MEM state: dm_re or dm_we=1. LOAD continues to WB with sel_r=0; STORE goes to IF.
  - 101 branch: rs2=IR[4:0].
    - Tested on b_val in EX: func[2:1]=0 taken if ==0; =1 if <0; =2 if >0; =3 always.
    - Taken: pc={10'b0, IR[26:5]}; else pc+1.
  - 110 stack: rs1=rd=31, sel_a=1.
    - func[2:1]=10 PUSH, alu_op 1010.
    - =01 POP, alu_op 1011.
    - =11 CALL, alu_op 1010, pc=pc+imm.
    - =00 RETURN, pc=a_val in EX, no write.
  - 111 MOVE: rs1=IR[9:5], rd=IR[4:0], alu_op 1001, sel_r=1.
- WB: rb_wr_en=1; pc updated (pc+1, or pc+imm for CALL). Next state IF.
- pc arithmetic is modulo 2^PC_WIDTH; pc=FFFFFFFF then +1 gives 0.
- Latency in cycles: ALU/ALUI/NOT/MOVE/PUSH/POP/CALL 5; LOAD 6; STORE 5; branch/RETURN 4; NOP 2.
- HALT: halted=1, all strobes 0, pc frozen. Leaves HALT only on reset.
- rd=0 writes are issued normally; R0 is hard-wired in the bank.

Test Plan:
- Reset release with IR stream NOP,NOP → pc 0→1→2, instr_re pulses every 2 cycles, all other strobes 0.
- ADD (001,func0) rd=3,rs1=1,rs2=2 at pc=4 → RR has rd1/rd2_en=1; WB has rb_wr_en=1, alu_op=0000, sel_r=1, rd=3; pc=5 exactly 5 cycles after IF.
- LOAD rd=5, rs2=2, imm=-1 (IR[25:10]=all 1s) → imm=FFFFFFFF; dm_re in MEM; then rb_wr_en with sel_r=0; 6 cycles total.
- BZ to 0x000123 with b_val=0 → pc=0x123; repeat with b_val=7 → pc+1; BMI with b_val=-1 → taken.
- CALL imm=+8 at pc=10 → alu_op=1010, rd=31, pc=18; RETURN with a_val=11 → pc=11, no rb_wr_en.
- HALT at pc=6 → halted=1 and pc=6 for 100 cycles. rst_n pulsed low during a STORE's MEM state → dm_we drops immediately, pc=RESET_PC, halted=0.
